// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe_if
// Description : Upstream/downstream handshake bundle for imm_gen_pipe.
//               "master" is the side that drives instructions and consumes
//               results; "slave" is the immediate generator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic [31:0]       Instr;
    logic [2:0]        ImmSel;
    logic [TAG_W-1:0]  in_tag;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [XLEN-1:0]   immediate;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output Instr, ImmSel, in_tag, in_valid, flush, out_ready,
        input  in_ready, immediate, out_tag, out_illegal, out_valid
    );

    modport slave (
        input  Instr, ImmSel, in_tag, in_valid, flush, out_ready,
        output in_ready, immediate, out_tag, out_illegal, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered RV32I/RV64I immediate generator (I/S/B/U/J, plus
//               optional CSR zimm) with a tag sideband and a valid/ready
//               interface backed by a one-entry skid buffer behind the
//               output register (two entries held in total).
//               Optional feature macro: IMM_ZICSR_EN enables ImmSel=6 (zimm);
//               without it ImmSel=6 is reported as illegal.
//               XLEN must be 32 or 64 and match the interface parameter.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] c_SEL_NONE = 3'd0;
    localparam logic [2:0] c_SEL_I    = 3'd1;
    localparam logic [2:0] c_SEL_S    = 3'd2;
    localparam logic [2:0] c_SEL_B    = 3'd3;
    localparam logic [2:0] c_SEL_U    = 3'd4;
    localparam logic [2:0] c_SEL_J    = 3'd5;
    localparam logic [2:0] c_SEL_Z    = 3'd6;

    logic              w_sign;
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic              w_ill;
    logic              w_accept;
    logic              w_out_free;
    logic              w_unused_opcode;

    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_imm;
    logic [TAG_W-1:0]  r_out_tag;
    logic              r_out_ill;
    logic              r_skid_valid;
    logic [XLEN-1:0]   r_skid_imm;
    logic [TAG_W-1:0]  r_skid_tag;
    logic              r_skid_ill;

    // The opcode field never contributes to any immediate.
    assign w_unused_opcode = &{1'b0, bus.Instr[6:0]};

    assign w_sign = bus.Instr[31];

    // Decode the selected format into a 32-bit sign-extended immediate.
    always_comb begin
        w_imm32 = 32'd0;
        w_ill   = 1'b0;
        case (bus.ImmSel)
            c_SEL_NONE: w_imm32 = 32'd0;
            c_SEL_I:    w_imm32 = {{20{w_sign}}, bus.Instr[31:20]};
            c_SEL_S:    w_imm32 = {{20{w_sign}}, bus.Instr[31:25], bus.Instr[11:7]};
            c_SEL_B:    w_imm32 = {{19{w_sign}}, bus.Instr[31], bus.Instr[7],
                                   bus.Instr[30:25], bus.Instr[11:8], 1'b0};
            c_SEL_U:    w_imm32 = {bus.Instr[31:12], 12'd0};
            c_SEL_J:    w_imm32 = {{11{w_sign}}, bus.Instr[31], bus.Instr[19:12],
                                   bus.Instr[20], bus.Instr[30:21], 1'b0};
            c_SEL_Z: begin
`ifdef IMM_ZICSR_EN
                // zimm is zero-extended; bit 31 is 0 so the XLEN widening below keeps it so.
                w_imm32 = {27'd0, bus.Instr[19:15]};
`else
                w_ill   = 1'b1;
`endif
            end
            default:    w_ill   = 1'b1;
        endcase
    end

    // Widen to XLEN; every 32-bit result already carries its final sign in bit 31.
    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm = w_imm32;
        end
    endgenerate

    // in_ready is the registered "skid empty" flag.
    assign w_accept   = bus.in_valid && !r_skid_valid;
    assign w_out_free = !r_out_valid || bus.out_ready;

    // Output register and skid entry: strict FIFO of depth two, flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_tag    <= '0;
            r_out_ill    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_tag   <= '0;
            r_skid_ill   <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // in_ready was low, so nothing new can arrive this cycle.
                r_out_valid  <= 1'b1;
                r_out_imm    <= r_skid_imm;
                r_out_tag    <= r_skid_tag;
                r_out_ill    <= r_skid_ill;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_imm    <= w_imm;
                r_out_tag    <= bus.in_tag;
                r_out_ill    <= w_ill;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            // Output is stalled: park the finished immediate in the skid entry.
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_imm;
            r_skid_tag   <= bus.in_tag;
            r_skid_ill   <= w_ill;
        end
    end

    assign bus.in_ready    = !r_skid_valid;
    assign bus.out_valid   = r_out_valid;
    assign bus.immediate   = r_out_imm;
    assign bus.out_tag     = r_out_tag;
    assign bus.out_illegal = r_out_ill;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench driving an XLEN=32 and an XLEN=64 instance
//               with identical stimulus; a depth-two FIFO model plus an
//               arithmetic immediate model supply all expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] tag;
    logic        inv;
    logic        ordy;
    logic        fl;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

    assign bus32.Instr     = instr;
    assign bus32.ImmSel    = sel;
    assign bus32.in_tag    = tag;
    assign bus32.in_valid  = inv;
    assign bus32.out_ready = ordy;
    assign bus32.flush     = fl;
    assign bus64.Instr     = instr;
    assign bus64.ImmSel    = sel;
    assign bus64.in_tag    = tag;
    assign bus64.in_valid  = inv;
    assign bus64.out_ready = ordy;
    assign bus64.flush     = fl;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        ill;
    } entry_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [63:0] exp;
        logic        ill;
    } vec_t;

    entry_t      q[$];
    logic [31:0] obs[$];
    vec_t        tbl[$];
    int          checks   = 0;
    int          failures = 0;
    bit          tbl_pending = 1'b0;
    logic [63:0] tbl_exp;
    logic        tbl_ill;
    entry_t      e5;

    // Compare one value, report on mismatch.
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Immediate value computed as a signed sum of weighted instruction fields.
    function automatic entry_t ref_model(input logic [31:0] ins, input logic [2:0] s,
                                         input logic [31:0] t);
        longint v;
        longint sg;
        entry_t e;
        sg    = longint'(ins[31]);
        v     = 0;
        e.ill = 1'b0;
        case (s)
            3'd1: v = longint'(ins[30:20]) - (sg << 11);
            3'd2: v = longint'(ins[11:7]) + (longint'(ins[30:25]) << 5) - (sg << 11);
            3'd3: v = (longint'(ins[11:8]) << 1) + (longint'(ins[30:25]) << 5)
                      + (longint'(ins[7]) << 11) - (sg << 12);
            3'd4: v = (longint'(ins[30:12]) << 12) - (sg << 31);
            3'd5: v = (longint'(ins[30:21]) << 1) + (longint'(ins[20]) << 11)
                      + (longint'(ins[19:12]) << 12) - (sg << 20);
            3'd6: begin
`ifdef IMM_ZICSR_EN
                v = longint'(ins[19:15]);
`else
                e.ill = 1'b1;
`endif
            end
            3'd7: e.ill = 1'b1;
            default: v = 0;
        endcase
        e.imm = v;
        e.tag = t;
        return e;
    endfunction

    task automatic add_vec(input logic [31:0] i, input logic [2:0] s,
                           input logic [63:0] x, input logic il);
        vec_t v;
        v.instr = i; v.sel = s; v.exp = x; v.ill = il;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [31:0] i, input logic [2:0] s, input logic [31:0] t,
                         input logic v, input logic r, input logic f);
        instr = i; sel = s; tag = t; inv = v; ordy = r; fl = f;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_valid32"}, 64'(bus32.out_valid), 64'd0);
        chk({pfx, "_valid64"}, 64'(bus64.out_valid), 64'd0);
        chk({pfx, "_ready32"}, 64'(bus32.in_ready), 64'd1);
        chk({pfx, "_ready64"}, 64'(bus64.in_ready), 64'd1);
        chk({pfx, "_imm32"}, 64'(bus32.immediate), 64'd0);
        chk({pfx, "_imm64"}, bus64.immediate, 64'd0);
        chk({pfx, "_tag32"}, 64'(bus32.out_tag), 64'd0);
        chk({pfx, "_ill64"}, 64'(bus64.out_illegal), 64'd0);
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        bit     exp_v;
        bit     exp_r;
        entry_t e;
        @(negedge clk);
        exp_v = q.size() > 0;
        exp_r = q.size() < 2;
        chk("out_valid32", 64'(bus32.out_valid), 64'(exp_v));
        chk("out_valid64", 64'(bus64.out_valid), 64'(exp_v));
        chk("in_ready32", 64'(bus32.in_ready), 64'(exp_r));
        chk("in_ready64", 64'(bus64.in_ready), 64'(exp_r));
        if (exp_v) begin
            e = q[0];
            chk("imm32", 64'(bus32.immediate), {32'd0, e.imm[31:0]});
            chk("imm64", bus64.immediate, e.imm);
            chk("tag32", 64'(bus32.out_tag), 64'(e.tag));
            chk("tag64", 64'(bus64.out_tag), 64'(e.tag));
            chk("ill32", 64'(bus32.out_illegal), 64'(e.ill));
            chk("ill64", 64'(bus64.out_illegal), 64'(e.ill));
        end
        if (tbl_pending) begin
            chk("tbl_imm32", 64'(bus32.immediate), {32'd0, tbl_exp[31:0]});
            chk("tbl_imm64", bus64.immediate, tbl_exp);
            chk("tbl_ill32", 64'(bus32.out_illegal), 64'(tbl_ill));
            chk("tbl_ill64", 64'(bus64.out_illegal), 64'(tbl_ill));
            tbl_pending = 1'b0;
        end
        if (bus32.out_valid && ordy) obs.push_back(bus32.out_tag);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (exp_v && ordy) void'(q.pop_front());
            if (inv && exp_r) q.push_back(ref_model(instr, sel, tag));
        end
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Hand-computed vectors (expected values given at 64 bits).
        add_vec(32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        add_vec(32'hFE112E23, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        add_vec(32'hFE000CE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        add_vec(32'h123450B7, 3'd4, 64'h0000_0000_1234_5000, 1'b0);
        add_vec(32'h7FF00093, 3'd1, 64'h0000_0000_0000_07FF, 1'b0);
        add_vec(32'hFFDFF06F, 3'd5, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        add_vec(32'h0080006F, 3'd5, 64'h0000_0000_0000_0008, 1'b0);
        add_vec(32'h800000B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0);
        add_vec(32'hFFFFFFFF, 3'd0, 64'h0, 1'b0);
        add_vec(32'hFFFFFFFF, 3'd7, 64'h0, 1'b1);
`ifdef IMM_ZICSR_EN
        add_vec(32'h3E0FD073, 3'd6, 64'h1F, 1'b0);
        // Instr[19:15] of this word is 5'b11110.
        add_vec(32'h3E0F1073, 3'd6, 64'h1E, 1'b0);
`else
        add_vec(32'h3E0FD073, 3'd6, 64'h0, 1'b1);
        add_vec(32'h3E0F1073, 3'd6, 64'h0, 1'b1);
`endif

        // Reset state.
        rst_n = 1'b0;
        drive(32'd0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back table at full throughput.
        for (int i = 0; i <= tbl.size(); i++) begin
            if (i < tbl.size()) drive(tbl[i].instr, tbl[i].sel, 32'(i), 1'b1, 1'b1, 1'b0);
            else                drive(32'd0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0);
            if (i > 0) begin
                tbl_pending = 1'b1;
                tbl_exp     = tbl[i-1].exp;
                tbl_ill     = tbl[i-1].ill;
            end
            tick();
        end
        tick();

        // Backpressure: tags 1,2 accepted, 3 waits, then drained in order.
        obs.delete();
        drive(32'hFFF00093, 3'd1, 32'd1, 1'b1, 1'b0, 1'b0); tick();
        drive(32'hFE112E23, 3'd2, 32'd2, 1'b1, 1'b0, 1'b0); tick();
        drive(32'h123450B7, 3'd4, 32'd3, 1'b1, 1'b0, 1'b0); tick();
        chk("t3_ready_low", 64'(bus32.in_ready), 64'd0);
        drive(32'h123450B7, 3'd4, 32'd3, 1'b1, 1'b1, 1'b0); tick();
        tick();
        drive(32'd0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0); tick();
        tick();
        chk("t3_count", 64'(obs.size()), 64'd3);
        for (int k = 0; k < 3 && k < obs.size(); k++)
            chk("t3_order", 64'(obs[k]), 64'(k + 1));

        // Flush with the skid full while tag 9 is offered.
        obs.delete();
        e5 = ref_model(32'hFE000CE3, 3'd3, 32'd5);
        drive(32'hFE000CE3, 3'd3, 32'd5, 1'b1, 1'b0, 1'b0); tick();
        drive(32'h7FF00093, 3'd1, 32'd6, 1'b1, 1'b0, 1'b0); tick();
        drive(32'h0080006F, 3'd5, 32'd9, 1'b1, 1'b0, 1'b1); tick();
        chk("t4_valid", 64'(bus32.out_valid), 64'd0);
        chk("t4_ready", 64'(bus64.in_ready), 64'd1);
        chk("t4_tag_kept", 64'(bus32.out_tag), 64'd5);
        chk("t4_imm_kept", bus64.immediate, e5.imm);
        // Flush while an input is accepted with the skid empty.
        drive(32'h0080006F, 3'd5, 32'd9, 1'b1, 1'b1, 1'b1); tick();
        drive(32'd0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0); tick();
        tick();
        chk("t4_no_tag9", 64'(obs.size()), 64'd0);

        // Asynchronous reset while stalled with both entries held.
        drive(32'h800000B7, 3'd4, 32'h61, 1'b1, 1'b0, 1'b0); tick();
        chk("t6_imm64", bus64.immediate, 64'hFFFF_FFFF_8000_0000);
        drive(32'hFFF00093, 3'd1, 32'h62, 1'b1, 1'b0, 1'b0); tick();
        drive(32'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive($urandom, 3'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            tick();
        end
        drive(32'd0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
